// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: one-bit-per-clock UART frame serializer (start, LSB-first data, optional parity, stop).
// Define UART_TX_PARITY_EN to compile in the PARITY state and parity generator.
module uart_tx_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] P_DATA,
   input  logic             DATA_VALID,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   output logic             TX_OUT,
   output logic             Busy
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4} state_t;
`else
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_t;
`endif
   state_t state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic tx_q, tx_d;
   logic busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic par_q, par_d;
   logic pen_q, pen_d;
`else
   logic unused_par;
   assign unused_par = PAR_EN ^ PAR_TYP;
`endif

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d = cnt_q;
`ifdef UART_TX_PARITY_EN
      par_d = par_q;
      pen_d = pen_q;
`endif
      case (state_q)
         IDLE: if (DATA_VALID) begin
            state_d = START;
            shift_d = P_DATA;
            cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            par_d = (^P_DATA) ^ PAR_TYP;
            pen_d = PAR_EN;
`endif
         end
         START: state_d = DATA;
         DATA: if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = pen_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
         end else begin
            cnt_d = cnt_q + 1'b1;
            shift_d = shift_q >> 1;
         end
`ifdef UART_TX_PARITY_EN
         PARITY: state_d = STOP;
`endif
         STOP: state_d = IDLE;
         default: begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d = '0;
         end
      endcase
      // Outputs are registered, so they are decoded from the state being entered.
      tx_d = 1'b1;
      if (state_d == START) tx_d = 1'b0;
      else if (state_d == DATA) tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      else if (state_d == PARITY) tx_d = par_q;
`endif
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q <= '0;
         tx_q <= 1'b1;
         busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q <= 1'b0;
         pen_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q <= cnt_d;
         tx_q <= tx_d;
         busy_q <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q <= par_d;
         pen_q <= pen_d;
`endif
      end
   end

   assign TX_OUT = tx_q;
   assign Busy = busy_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized frame-level checks of uart_tx_serializer against a bit-list model.
module tb_uart_tx_serializer;
   logic CLK = 1'b0, RST = 1'b1, DATA_VALID = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0;
   logic [7:0] P_DATA = '0;
   logic TX_OUT, Busy;
   int errors = 0, checks = 0;
`ifdef UART_TX_PARITY_EN
   localparam bit HAS_PAR = 1'b1;
`else
   localparam bit HAS_PAR = 1'b0;
`endif

   uart_tx_serializer #(.WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   // Expected line levels, element 0 first: start, data LSB first, optional parity, stop.
   function automatic int model_frame(input logic [7:0] d, input logic pen, input logic ptyp, output logic [10:0] bits);
      logic p;
      p = (($countones(d) % 2) == 1) ^ ptyp;
      if (HAS_PAR && pen) begin
         bits = {1'b1, p, d, 1'b0};
         return 11;
      end
      bits = {2'b11, d, 1'b0};
      return 10;
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp, input bit scramble, input string name);
      logic [10:0] bits;
      int n;
      n = model_frame(d, pen, ptyp, bits);
      P_DATA = d;
      PAR_EN = pen;
      PAR_TYP = ptyp;
      DATA_VALID = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         checks++;
         if ({Busy, TX_OUT} !== {1'b1, bits[i]}) begin
            errors++;
            $display("FAIL %s bit%0d: busy,tx=%b%b expected 1%b", name, i, Busy, TX_OUT, bits[i]);
         end
         DATA_VALID = scramble ? 1'($urandom) : 1'b0;
         if (scramble) begin
            P_DATA = 8'($urandom);
            PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom);
         end
      end
      @(negedge CLK);
      checks++;
      if ({Busy, TX_OUT} !== 2'b01) begin
         errors++;
         $display("FAIL %s idle: busy,tx=%b%b expected 01", name, Busy, TX_OUT);
      end
      DATA_VALID = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({Busy, TX_OUT} !== 2'b01) begin
         errors++;
         $display("FAIL reset_state: busy,tx=%b%b expected 01", Busy, TX_OUT);
      end
      RST = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         checks++;
         if ({Busy, TX_OUT} !== 2'b01) begin
            errors++;
            $display("FAIL reset_idle cycle%0d: busy,tx=%b%b expected 01", i, Busy, TX_OUT);
         end
      end
   endtask

   task automatic test_fixed_frames;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, "a5_nopar");
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5_even");
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, "a5_odd");
      send_frame(8'h01, 1'b1, 1'b0, 1'b0, "01_even");
   endtask

   task automatic test_random;
      for (int f = 0; f < 40; f++) begin
         send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b1, "random");
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            @(negedge CLK);
            checks++;
            if ({Busy, TX_OUT} !== 2'b01) begin
               errors++;
               $display("FAIL random_gap: busy,tx=%b%b expected 01", Busy, TX_OUT);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [10:0] b1, b2;
      int n1, n2;
      n1 = model_frame(8'h3C, 1'b0, 1'b0, b1);
      n2 = model_frame(8'hC3, 1'b0, 1'b0, b2);
      P_DATA = 8'h3C;
      PAR_EN = 1'b0;
      DATA_VALID = 1'b1;
      for (int i = 0; i < n1; i++) begin
         @(negedge CLK);
         checks++;
         if ({Busy, TX_OUT} !== {1'b1, b1[i]}) begin
            errors++;
            $display("FAIL b2b_first bit%0d: busy,tx=%b%b expected 1%b", i, Busy, TX_OUT, b1[i]);
         end
         if (i == 3) P_DATA = 8'hC3;
      end
      @(negedge CLK);
      checks++;
      if ({Busy, TX_OUT} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_gap: busy,tx=%b%b expected 01", Busy, TX_OUT);
      end
      for (int i = 0; i < n2; i++) begin
         @(negedge CLK);
         checks++;
         if ({Busy, TX_OUT} !== {1'b1, b2[i]}) begin
            errors++;
            $display("FAIL b2b_second bit%0d: busy,tx=%b%b expected 1%b", i, Busy, TX_OUT, b2[i]);
         end
         DATA_VALID = 1'b0;
      end
      @(negedge CLK);
      checks++;
      if ({Busy, TX_OUT} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_end: busy,tx=%b%b expected 01", Busy, TX_OUT);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [10:0] bits;
      void'(model_frame(8'hA5, 1'b0, 1'b0, bits));
      P_DATA = 8'hA5;
      PAR_EN = 1'b0;
      DATA_VALID = 1'b1;
      for (int i = 0; i <= 5; i++) begin
         @(negedge CLK);
         checks++;
         if ({Busy, TX_OUT} !== {1'b1, bits[i]}) begin
            errors++;
            $display("FAIL midreset_pre bit%0d: busy,tx=%b%b expected 1%b", i, Busy, TX_OUT, bits[i]);
         end
         DATA_VALID = 1'b0;
      end
      RST = 1'b1;
      @(negedge CLK);
      checks++;
      if ({Busy, TX_OUT} !== 2'b01) begin
         errors++;
         $display("FAIL midreset_abort: busy,tx=%b%b expected 01", Busy, TX_OUT);
      end
      RST = 1'b0;
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0, "after_reset");
   endtask

   task automatic test_upstream_word;
      logic [15:0] word;
      logic [7:0] byte_v;
      word = 16'hBEEF;
      for (int b = 0; b < 2; b++) begin
         byte_v = (b == 0) ? word[7:0] : word[15:8];
         for (int t = 0; t < 50 && Busy !== 1'b0; t++) @(negedge CLK);
         checks++;
         if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL upstream_wait byte%0d: busy=%b expected 0 within 50 cycles", b, Busy);
         end
         send_frame(byte_v, 1'b0, 1'b0, 1'b0, "upstream");
      end
   endtask

   initial begin
      test_reset();
      test_fixed_frames();
      test_back_to_back();
      test_reset_mid_frame();
      test_upstream_word();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
